// File: rtl/axi_arb_pkg.sv
// axi_arb_pkg: shared widths, slave codes, FSM states, responses and address map for the AR arbiter
package axi_arb_pkg;

    localparam int AXI_ID_BITS   = 4;
    localparam int AXI_IDS_BITS  = AXI_ID_BITS + 4;
    localparam int AXI_ADDR_BITS = 32;
    localparam int AXI_LEN_BITS  = 4;
    localparam int AXI_SIZE_BITS = 3;

    localparam logic [2:0] SLV_S0  = 3'd0;
    localparam logic [2:0] SLV_S1  = 3'd1;
    localparam logic [2:0] SLV_S2  = 3'd2;
    localparam logic [2:0] SLV_S3  = 3'd3;
    localparam logic [2:0] SLV_S4  = 3'd4;
    localparam logic [2:0] SLV_S5  = 3'd5;
    localparam logic [2:0] SLV_DEF = 3'd6;

    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [AXI_ADDR_BITS-1:0] S0_BASE  = 32'h0000_0000;
    localparam logic [AXI_ADDR_BITS-1:0] S0_LIMIT = 32'h0000_3FFF;
    localparam logic [AXI_ADDR_BITS-1:0] S1_BASE  = 32'h0001_0000;
    localparam logic [AXI_ADDR_BITS-1:0] S1_LIMIT = 32'h0001_FFFF;
    localparam logic [AXI_ADDR_BITS-1:0] S2_BASE  = 32'h0002_0000;
    localparam logic [AXI_ADDR_BITS-1:0] S2_LIMIT = 32'h0002_FFFF;

    // S0 starts at zero, so only its upper limit needs comparing
    function automatic logic [2:0] addr_decode(input logic [AXI_ADDR_BITS-1:0] addr,
                                               input logic [2:0] def);
        return (addr <= S0_LIMIT)                    ? SLV_S0 :
               (addr >= S1_BASE && addr <= S1_LIMIT) ? SLV_S1 :
               (addr >= S2_BASE && addr <= S2_LIMIT) ? SLV_S2 : def;
    endfunction

endpackage

// File: rtl/default_slave_r.sv
// default_slave_r: DECERR read-data generator for unmapped addresses (beat counter, latched ID/LEN)
module default_slave_r
    import axi_arb_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load,
    input  logic                    active,
    input  logic [AXI_IDS_BITS-1:0] id_in,
    input  logic [AXI_LEN_BITS-1:0] len_in,
    input  logic                    rready,
    output logic [AXI_IDS_BITS-1:0] rid,
    output logic [1:0]              rresp,
    output logic                    rlast,
    output logic                    rvalid
);

    logic [AXI_IDS_BITS-1:0] id_q;
    logic [AXI_LEN_BITS-1:0] len_q;
    logic [AXI_LEN_BITS-1:0] cnt;

    // capture ID and burst length at the address handshake
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            id_q  <= '0;
            len_q <= '0;
        end else if (load) begin
            id_q  <= id_in;
            len_q <= len_in;
        end
    end

    // beat counter: held at zero outside a default-slave burst, stops at the last beat so it never wraps
    always_ff @(posedge clk) begin
        if (!rst_n || !active)
            cnt <= '0;
        else if (rvalid && rready && !rlast)
            cnt <= cnt + 1'b1;
    end

    assign rvalid = active;
    assign rlast  = active && (cnt == len_q);
    assign rresp  = active ? RESP_DECERR : RESP_OKAY;
    assign rid    = active ? id_q : '0;

endmodule

// File: rtl/ar_arbiter.sv
// ar_arbiter: two-master AXI read-address arbiter with address decode and DECERR default slave; AR_ARB_ROUND_ROBIN_EN selects round-robin ties
module ar_arbiter
    import axi_arb_pkg::*;
#(
    parameter int         NUM_MASTERS = 2,
    parameter logic [2:0] DEF_SLAVE   = SLV_DEF
) (
    input  logic                     ACLK,
    input  logic                     ARESETn,
    input  logic [AXI_ID_BITS-1:0]   ARID_M0,
    input  logic [AXI_ADDR_BITS-1:0] ARADDR_M0,
    input  logic [AXI_LEN_BITS-1:0]  ARLEN_M0,
    input  logic [AXI_SIZE_BITS-1:0] ARSIZE_M0,
    input  logic [1:0]               ARBURST_M0,
    input  logic                     ARVALID_M0,
    output logic                     ARREADY_M0,
    input  logic [AXI_ID_BITS-1:0]   ARID_M1,
    input  logic [AXI_ADDR_BITS-1:0] ARADDR_M1,
    input  logic [AXI_LEN_BITS-1:0]  ARLEN_M1,
    input  logic [AXI_SIZE_BITS-1:0] ARSIZE_M1,
    input  logic [1:0]               ARBURST_M1,
    input  logic                     ARVALID_M1,
    output logic                     ARREADY_M1,
    output logic [AXI_IDS_BITS-1:0]  ARID_BUS,
    output logic [AXI_ADDR_BITS-1:0] ARADDR_BUS,
    output logic [AXI_LEN_BITS-1:0]  ARLEN_BUS,
    output logic [AXI_SIZE_BITS-1:0] ARSIZE_BUS,
    output logic [1:0]               ARBURST_BUS,
    output logic                     ARVALID_BUS,
    input  logic                     ARREADY_BUS,
    output logic [2:0]               slave,
    input  logic                     RVALID_BUS,
    input  logic                     RREADY_BUS,
    input  logic                     RLAST_BUS,
    output logic [AXI_IDS_BITS-1:0]  RID_DEF,
    output logic [1:0]               RRESP_DEF,
    output logic                     RLAST_DEF,
    output logic                     RVALID_DEF,
    input  logic                     RREADY_DEF
);

    localparam int GW = $clog2(NUM_MASTERS);

    state_t        state;
    logic [GW-1:0] grant;
    logic [GW-1:0] win;
    logic [2:0]    slave_q;
    logic          m1, in_addr, is_def, ar_rdy, ar_hs, r_done;
`ifdef AR_ARB_ROUND_ROBIN_EN
    logic          last_m1;

    // round-robin: a tie goes to the master that was not granted last
    always_comb win = (ARVALID_M0 && (!ARVALID_M1 || last_m1)) ? '0 : '1;
`else
    // fixed priority: M0 wins every tie
    always_comb win = ARVALID_M0 ? '0 : '1;
`endif

    assign m1      = grant != '0;
    assign in_addr = state == ADDR;
    assign is_def  = slave_q == DEF_SLAVE;
    assign ar_rdy  = in_addr && (is_def || ARREADY_BUS);
    assign ar_hs   = ARVALID_BUS && ar_rdy;
    assign r_done  = (state == DATA) && (is_def ? (RVALID_DEF && RREADY_DEF && RLAST_DEF)
                                                : (RVALID_BUS && RREADY_BUS && RLAST_BUS));

    assign ARREADY_M0  = ar_rdy && !m1;
    assign ARREADY_M1  = ar_rdy && m1;
    assign ARVALID_BUS = in_addr && (m1 ? ARVALID_M1 : ARVALID_M0);
    assign ARID_BUS    = in_addr ? {4'(grant), m1 ? ARID_M1 : ARID_M0} : '0;
    assign ARADDR_BUS  = in_addr ? (m1 ? ARADDR_M1 : ARADDR_M0) : '0;
    assign ARLEN_BUS   = in_addr ? (m1 ? ARLEN_M1 : ARLEN_M0) : '0;
    assign ARSIZE_BUS  = in_addr ? (m1 ? ARSIZE_M1 : ARSIZE_M0) : '0;
    assign ARBURST_BUS = in_addr ? (m1 ? ARBURST_M1 : ARBURST_M0) : '0;
    assign slave       = slave_q;

    // grant/steer FSM: grant and slave select only change in IDLE and stay fixed until the last beat
    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            state   <= IDLE;
            grant   <= '0;
            slave_q <= DEF_SLAVE;
`ifdef AR_ARB_ROUND_ROBIN_EN
            last_m1 <= 1'b1;
`endif
        end else begin
            unique case (state)
                IDLE: if (ARVALID_M0 || ARVALID_M1) begin
                    grant   <= win;
                    slave_q <= addr_decode(win != '0 ? ARADDR_M1 : ARADDR_M0, DEF_SLAVE);
                    state   <= ADDR;
                end
                ADDR: if (ar_hs) state <= DATA;
                DATA: if (r_done) begin
                    state   <= IDLE;
                    slave_q <= DEF_SLAVE;
`ifdef AR_ARB_ROUND_ROBIN_EN
                    last_m1 <= m1;
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

    default_slave_r u_def (
        .clk    (ACLK),
        .rst_n  (ARESETn),
        .load   (ar_hs),
        .active ((state == DATA) && is_def),
        .id_in  (ARID_BUS),
        .len_in (ARLEN_BUS),
        .rready (RREADY_DEF),
        .rid    (RID_DEF),
        .rresp  (RRESP_DEF),
        .rlast  (RLAST_DEF),
        .rvalid (RVALID_DEF)
    );

endmodule
